// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a
// saturating bubble counter. Hazard logic is present only when ID_EX_HAZARD_EN is defined.
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_regwrite_i,
    input  logic              id_alusrc_i,
    input  logic              id_regdst_i,
    input  logic              id_branch_i,
    input  logic              id_memwrite_i,
    input  logic              id_memread_i,
    input  logic              id_memtoreg_i,
    input  logic [2:0]        id_aluop_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [RA_W-1:0]   id_rs_i,
    input  logic [RA_W-1:0]   id_rt_i,
    input  logic [RA_W-1:0]   id_rd_i,
    output logic              ex_regwrite_o,
    output logic              ex_alusrc_o,
    output logic              ex_regdst_o,
    output logic              ex_branch_o,
    output logic              ex_memwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memtoreg_o,
    output logic [2:0]        ex_aluop_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [RA_W-1:0]   ex_rs_o,
    output logic [RA_W-1:0]   ex_rt_o,
    output logic [RA_W-1:0]   ex_rd_o,
    output logic              ex_valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic              regwrite;
        logic              alusrc;
        logic              regdst;
        logic              branch;
        logic              memwrite;
        logic              memread;
        logic              memtoreg;
        logic [2:0]        aluop;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [RA_W-1:0]   rs;
        logic [RA_W-1:0]   rt;
        logic [RA_W-1:0]   rd;
        logic              valid;
    } ex_t;

    ex_t  ex_d, ex_q;
    logic haz;
    logic bubble;

    always_comb begin
`ifdef ID_EX_HAZARD_EN
        haz = ex_q.valid & ex_q.memread & (ex_q.rt != '0) &
              ((ex_q.rt == id_rs_i) | (ex_q.rt == id_rt_i));
`else
        haz = 1'b0;
`endif
        // Flush wins: the dependent instruction is squashed, so no upstream stall is needed.
        stall_o = haz & ~flush_i;
        bubble  = flush_i | haz;

        ex_d.regwrite = id_regwrite_i;
        ex_d.alusrc   = id_alusrc_i;
        ex_d.regdst   = id_regdst_i;
        ex_d.branch   = id_branch_i;
        ex_d.memwrite = id_memwrite_i;
        ex_d.memread  = id_memread_i;
        ex_d.memtoreg = id_memtoreg_i;
        ex_d.aluop    = id_aluop_i;
        ex_d.rs_data  = id_rs_data_i;
        ex_d.rt_data  = id_rt_data_i;
        ex_d.imm      = id_imm_i;
        ex_d.pc4      = id_pc4_i;
        ex_d.rs       = id_rs_i;
        ex_d.rt       = id_rt_i;
        ex_d.rd       = id_rd_i;
        ex_d.valid    = 1'b1;

        // A bubble only needs its side-effecting controls cleared; data fields are don't-care.
        if (bubble) begin
            ex_d.regwrite = 1'b0;
            ex_d.alusrc   = 1'b0;
            ex_d.regdst   = 1'b0;
            ex_d.branch   = 1'b0;
            ex_d.memwrite = 1'b0;
            ex_d.memread  = 1'b0;
            ex_d.memtoreg = 1'b0;
            ex_d.aluop    = 3'b000;
            ex_d.valid    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef ID_EX_HAZARD_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign ex_regwrite_o = ex_q.regwrite;
    assign ex_alusrc_o   = ex_q.alusrc;
    assign ex_regdst_o   = ex_q.regdst;
    assign ex_branch_o   = ex_q.branch;
    assign ex_memwrite_o = ex_q.memwrite;
    assign ex_memread_o  = ex_q.memread;
    assign ex_memtoreg_o = ex_q.memtoreg;
    assign ex_aluop_o    = ex_q.aluop;
    assign ex_rs_data_o  = ex_q.rs_data;
    assign ex_rt_data_o  = ex_q.rt_data;
    assign ex_imm_o      = ex_q.imm;
    assign ex_pc4_o      = ex_q.pc4;
    assign ex_rs_o       = ex_q.rs;
    assign ex_rt_o       = ex_q.rt;
    assign ex_rd_o       = ex_q.rd;
    assign ex_valid_o    = ex_q.valid;

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline stage register for the five-stage pipeline CPU. It sits directly downstream of the instruction decoder and register file. Each cycle it captures the decoder's control bundle, the register operands, the sign-extended immediate, the register addresses and PC+4, and presents them to the EX stage. It also contains the load-use hazard detector, inserts bubbles on hazard or branch flush, and counts hazard bubbles for performance debug.

## Interface
- DATA_W, 32, width of operand, immediate and PC fields
- RA_W, 5, register address width
- CNT_W, 16, width of the hazard bubble counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  branch taken in a later stage; squash the instruction currently in ID
- id_regwrite_i, id_alusrc_i, id_regdst_i, id_branch_i, id_memwrite_i, id_memread_i, id_memtoreg_i  in  1 each  decoder control bits
- id_aluop_i  in  3  decoder ALU op code
- id_rs_data_i, id_rt_data_i  in  DATA_W  register file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_pc4_i  in  DATA_W  PC+4 of the ID instruction
- id_rs_i, id_rt_i, id_rd_i  in  RA_W  register addresses of the ID instruction
- ex_* outputs  out  same widths  registered copies of every id_* input above
- ex_valid_o  out  1  EX holds a real instruction (0 = bubble)
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- stall_cnt_o  out  CNT_W  saturating count of hazard bubbles inserted

## Operation
- Reset (rst_i high, async): every ex_* output, ex_valid_o and stall_cnt_o go to 0 immediately; stall_o evaluates to 0, because it depends on ex_valid_o.
- Hazard term: haz = ex_valid_o & ex_memread_o & (ex_rt_o != 0) & (ex_rt_o == id_rs_i | ex_rt_o == id_rt_i).
- stall_o = haz & ~flush_i. Flush has priority, because the dependent ID instruction is squashed anyway.
- Per rising edge, one of three cases applies, in priority order:
  - Bubble (flush_i | haz): all seven 1-bit control outputs go to 0, ex_aluop_o goes to 0, and ex_valid_o goes to 0. The data/address/PC fields still load from the id_* inputs; they are don't-care downstream. With no write, memory access or branch enabled, a bubble is architecturally a nop.
  - Normal: all ex_* outputs load the id_* inputs and ex_valid_o goes to 1.
  - There is no hold case. This stage never stalls itself; when it stalls, it stalls upstream and issues a bubble.
- Counter: stall_cnt_o increments by 1 on each edge where stall_o = 1. It saturates at 2^CNT_W-1 and holds there. Flush-only bubbles are not counted.
- A load followed by a dependent instruction yields exactly one bubble. On the next cycle ex_valid_o = 0, so haz drops and the held ID instruction issues.

## Timing
- Latency is 1 cycle from id_* inputs to ex_* outputs.
- stall_o is combinational from registered state and the id_* address inputs, and is valid in the same cycle.
- A reset asserted mid-operation discards in-flight content. After deassertion, the first edge loads normally; the first cycle out of reset is treated as valid.
- When flush_i and haz are both high: one bubble, stall_o = 0, and the counter does not increment.
- Back-to-back loads: the second load depends on the first only through rs/rt matching, and the same rule applies.

## Configuration
- ID_EX_HAZARD_EN defined: load-use detection, stall_o and stall_cnt_o behave as above.
- ID_EX_HAZARD_EN undefined: haz is hardwired to 0, stall_o is constant 0 and stall_cnt_o is constant 0. Bubbles come only from flush_i, and software must schedule load delay slots.

## Test plan
- Reset with all inputs driven nonzero -> all ex_* = 0, ex_valid_o = 0, stall_cnt_o = 0. Then release reset, drive an ADD (regdst=1, aluop=3'b010, regwrite=1, rs=1, rt=2, rd=3) -> one edge later ex_valid_o = 1 and the outputs match the inputs.
- LW (memread=1, memtoreg=1, rt=8) followed by ADD with rs=8 -> stall_o = 1 for one cycle; the next EX is a bubble (regwrite=0, valid=0); stall_cnt_o = 1; the ADD enters EX on the following edge.
- LW with rt=0 followed by an instruction with rs=0 -> stall_o = 0, no bubble, counter unchanged.
- flush_i = 1 while a valid SW is in ID -> ex_memwrite_o = 0, ex_valid_o = 0, counter unchanged. Flush coincident with a load-use hazard -> stall_o = 0, one bubble, counter unchanged.
- Force 2^16+3 consecutive hazard cycles (CNT_W=16) -> stall_cnt_o holds 16'hFFFF.
- Build without ID_EX_HAZARD_EN and rerun the LW/ADD scenario -> stall_o = 0, the ADD enters EX one cycle after the LW, stall_cnt_o = 0.
